jtpopeye_dma: RTL and testbench
===============================

// Module: jtpopeye_dma
// PURPOSE
//  Bus-master DMA engine: the requester/reader side of the main board's DMA port.
//  On each VB rising edge it:
//   - requests the Z80 bus (busrq_n) and waits for busak_n;
//   - drives dma_cs/AD_DMA to read LEN bytes of object RAM (main RAM 0x8400+AD_DMA);
//   - streams them as write strobes into the video object buffer, then releases the bus.
// PARAMETERS
//  LEN      768     bytes per transfer (1..1024)
//  START    10'h000 first AD_DMA address; address wraps mod 1024
//  TIMEOUT  255     cen cycles to wait for busak_n before abandoning the request
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous active-low reset
//  cen       in   1   CPU clock enable; all state advances only on cen
//  VB        in   1   vertical blank; rising edge (sampled on cen) triggers a transfer
//  busrq_n   out  1   bus request to CPU, active low
//  busak_n   in   1   bus acknowledge from CPU, active low
//  dma_cs    out  1   selects DMA address on main RAM port
//  AD_DMA    out  10  main RAM read address
//  DD_DMA    in   8   main RAM data; valid one cen after AD_DMA is presented
//  obj_we    out  1   object buffer write strobe, one cen wide
//  obj_addr  out  10  object buffer write address (0..LEN-1)
//  obj_data  out  8   object buffer write data
//  busy      out  1   high from request until bus release
//  done      out  1   one-cen pulse on successful completion
//  err       out  1   sticky: timeout or busak_n lost mid-transfer; cleared by reset only
// BEHAVIOUR
//  Reset (asynchronous, active-low):
//   - busrq_n=1, all other outputs 0, state IDLE, VB edge register 0.
//   - Reset mid-transfer releases the bus immediately.
//  States (transitions on cen):
//   IDLE -> REQ on VB rising edge (VB=1, previous sampled VB=0).
//   REQ: busrq_n=0, busy=1, counting wait cycles.
//    - busak_n==0 -> XFER with dma_cs=1, AD_DMA=START, index=0.
//    - wait count reaches TIMEOUT -> IDLE: busrq_n=1, busy=0, err=1.
//   XFER, each cen:
//    - AD_DMA <= AD_DMA+1 (10-bit wrap);
//    - if index>0: obj_we=1, obj_addr=index-1, obj_data=DD_DMA;
//    - index++. After address START+LEN-1 is presented -> FLUSH.
//   FLUSH: writes last byte (obj_addr=LEN-1); dma_cs stays 1 this cen -> RELEASE.
//   RELEASE: dma_cs=0, busrq_n=1, done=1 for one cen, busy=0 -> IDLE.
//  Latency:
//   - first obj_we lands 2 cen after busak_n is sampled low;
//   - busrq_n rises LEN+2 cen after grant.
//  busak_n==1 sampled during XFER/FLUSH:
//   - abort to IDLE, busrq_n=1, dma_cs=0, err=1, no further obj_we.
//  VB edges while busy are ignored, no retrigger. VB held high does not retrigger.
//  obj_we asserted only with cen; between cen pulses outputs hold and obj_we is 0.
//  Exactly LEN obj_we pulses per successful transfer, addresses 0..LEN-1 ascending, no gaps.
// TESTING
//  1 VB 0->1, busak_n granted 3 cen later, RAM model q=addr[7:0]
//    -> 768 obj_we, obj_data[i]=i[7:0], done once, busrq_n high 770 cen after grant.
//  2 START=10'h3F0, LEN=32 -> AD_DMA runs 3F0..3FF,000..00F;
//    obj_addr 0..31 with matching data.
//  3 busak_n never asserted -> after 255 cen busrq_n=1, err=1, busy=0, no obj_we.
//  4 busak_n released at index 100 -> immediate abort, err=1, at most 100 obj_we, dma_cs=0.
//  5 second VB edge mid-transfer and VB held high -> exactly one transfer per rising edge.
//  6 rst_n low at index 50 -> busrq_n=1, dma_cs=0 asynchronously;
//    next VB edge runs a clean full transfer.

Source files
------------

// File: rtl/jtpopeye_dma.sv
// Bus-master DMA: on each VB rising edge, grabs the Z80 bus and copies LEN bytes of object RAM into the object buffer.
// All state advances on cen only; obj_we/done are gated with cen so they last exactly one cen.
module jtpopeye_dma #(
    parameter int         LEN     = 768,
    parameter logic [9:0] START   = 10'h000,
    parameter int         TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       VB,
    output logic       busrq_n,
    input  logic       busak_n,
    output logic       dma_cs,
    output logic [9:0] AD_DMA,
    input  logic [7:0] DD_DMA,
    output logic       obj_we,
    output logic [9:0] obj_addr,
    output logic [7:0] obj_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, REQ, XFER, FLUSH, RELEASE} state_t;

    localparam logic [10:0] LAST    = 11'(LEN - 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        vb_q;
    logic        busrq_q, busrq_d;
    logic        cs_q, cs_d;
    logic [9:0]  ad_q, ad_d;
    logic [10:0] idx_q, idx_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        we_q, we_d;
    logic [9:0]  oaddr_q, oaddr_d;
    logic [7:0]  odata_q, odata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        vb_rise;

    assign vb_rise = VB & ~vb_q;

    always_comb begin
        state_d = state_q;
        busrq_d = busrq_q;
        cs_d    = cs_q;
        ad_d    = ad_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        we_d    = 1'b0;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (vb_rise) begin
                    state_d = REQ;
                    busrq_d = 1'b0;
                    busy_d  = 1'b1;
                    wcnt_d  = '0;
                end
            end
            REQ: begin
                if (!busak_n) begin
                    state_d = XFER;
                    cs_d    = 1'b1;
                    ad_d    = START;
                    idx_d   = '0;
                end else if (wcnt_q == TO_LAST) begin
                    state_d = IDLE;
                    busrq_d = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            XFER, FLUSH: begin
                if (busak_n) begin
                    // CPU took the bus back: drop everything, suppress this write
                    state_d = IDLE;
                    busrq_d = 1'b1;
                    cs_d    = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (state_q == XFER) begin
                    // RAM data lags the address by one cen, so writes trail by one index
                    ad_d  = ad_q + 10'd1;
                    idx_d = idx_q + 11'd1;
                    if (idx_q != 11'd0) begin
                        we_d    = 1'b1;
                        oaddr_d = 10'(idx_q - 11'd1);
                        odata_d = DD_DMA;
                    end
                    if (idx_q == LAST) state_d = FLUSH;
                end else begin
                    we_d    = 1'b1;
                    oaddr_d = 10'(LAST);
                    odata_d = DD_DMA;
                    cs_d    = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                busrq_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vb_q    <= 1'b0;
            busrq_q <= 1'b1;
            cs_q    <= 1'b0;
            ad_q    <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (cen) begin
            state_q <= state_d;
            vb_q    <= VB;
            busrq_q <= busrq_d;
            cs_q    <= cs_d;
            ad_q    <= ad_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busrq_n  = busrq_q;
    assign dma_cs   = cs_q;
    assign AD_DMA   = ad_q;
    assign obj_we   = we_q & cen;
    assign obj_addr = oaddr_q;
    assign obj_data = odata_q;
    assign busy     = busy_q;
    assign done     = done_q & cen;
    assign err      = err_q;

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Directed bench for jtpopeye_dma: default instance (LEN 768, START 0) and a wrapping instance (LEN 32, START 3F0).
module tb_jtpopeye_dma;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b1;
    logic       vb = 1'b0, busak_n = 1'b1;
    logic       vb2 = 1'b0, busak2_n = 1'b1;
    logic [7:0] dd = 8'd0, dd2 = 8'd0;

    logic       busrq_n, dma_cs, obj_we, busy, done, err;
    logic [9:0] ad, obj_addr;
    logic [7:0] obj_data;
    logic       busrq2_n, dma_cs2, obj_we2, busy2, done2, err2;
    logic [9:0] ad2, obj_addr2;
    logic [7:0] obj_data2;

    int total = 0, bad = 0;
    int wr1 = 0, dn1 = 0, wr2 = 0, dn2 = 0;
    logic [17:0] log1 [4096];
    logic [17:0] log2 [64];

    jtpopeye_dma u_dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .VB(vb),
        .busrq_n(busrq_n), .busak_n(busak_n), .dma_cs(dma_cs), .AD_DMA(ad), .DD_DMA(dd),
        .obj_we(obj_we), .obj_addr(obj_addr), .obj_data(obj_data),
        .busy(busy), .done(done), .err(err)
    );

    jtpopeye_dma #(.LEN(32), .START(10'h3F0), .TIMEOUT(255)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .VB(vb2),
        .busrq_n(busrq2_n), .busak_n(busak2_n), .dma_cs(dma_cs2), .AD_DMA(ad2), .DD_DMA(dd2),
        .obj_we(obj_we2), .obj_addr(obj_addr2), .obj_data(obj_data2),
        .busy(busy2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    // object RAM models: q = addr[7:0], one cen of read latency
    always @(posedge clk) begin
        if (cen) begin
            dd  <= ad[7:0];
            dd2 <= ad2[7:0];
        end
    end

    always @(negedge clk) begin
        if (obj_we) begin
            log1[wr1 % 4096] <= {obj_addr, obj_data};
            wr1 <= wr1 + 1;
        end
        if (done) dn1 <= dn1 + 1;
        if (obj_we2) begin
            log2[wr2 % 64] <= {obj_addr2, obj_data2};
            wr2 <= wr2 + 1;
        end
        if (done2) dn2 <= dn2 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int bad1(input int base, input int n, input logic [9:0] start);
        int         cnt;
        logic [9:0] a;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            a = start + 10'(i);
            if (log1[(base + i) % 4096] !== {10'(i), a[7:0]}) cnt++;
        end
        return cnt;
    endfunction

    // VB edge, grant after gdelay cen, run until bus released; optional VB glitch at cycle glitch_at
    task automatic run1(input int gdelay, input int glitch_at, output int lat_rel, output int lat_we);
        vb = 1'b0;
        tick();
        vb = 1'b1;
        tick();
        chk("req_busrq_busy", {busrq_n, busy}, 2'b01);
        repeat (gdelay - 1) tick();
        busak_n = 1'b0;
        tick();
        lat_rel = -1;
        lat_we  = -1;
        for (int n = 1; n <= 2000; n++) begin
            tick();
            if (lat_we < 0 && obj_we) lat_we = n;
            if (n == glitch_at) vb = 1'b0;
            if (n == glitch_at + 1) vb = 1'b1;
            if (busrq_n) begin
                lat_rel = n;
                break;
            end
        end
        busak_n = 1'b1;
    endtask

    initial begin
        int   lat_rel, lat_we, base, dbase, w, mism, lat2;
        logic ok;

        // reset values
        repeat (2) tick();
        chk("rst_busrq_n", busrq_n, 1'b1);
        chk("rst_outputs", {dma_cs, ad, obj_we, obj_addr, obj_data, busy, done, err}, 64'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_no_req", {busrq_n, busy}, 2'b10);

        // full transfer, grant 3 cen later, second VB edge mid-transfer
        base  = wr1;
        dbase = dn1;
        run1(3, 100, lat_rel, lat_we);
        tick();
        chk("t1_release_lat", lat_rel, 770);
        chk("t1_first_we_lat", lat_we, 2);
        chk("t1_we_count", wr1 - base, 768);
        chk("t1_data_mism", bad1(base, 768, 10'h000), 0);
        chk("t1_done_count", dn1 - dbase, 1);
        chk("t1_idle_outs", {busrq_n, dma_cs, busy, err}, 4'b1000);
        // VB still high: no retrigger
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (busrq_n !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("t5_no_retrigger", ok, 1'b1);
        chk("t5_one_done", dn1 - dbase, 1);

        // wrapping instance: START 3F0, LEN 32
        vb2 = 1'b0;
        tick();
        vb2 = 1'b1;
        tick();
        chk("t2_req", busrq2_n, 1'b0);
        busak2_n = 1'b0;
        tick();
        chk("t2_ad_start", ad2, 10'h3F0);
        base = wr2;
        dbase = dn2;
        lat2 = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (n == 16) chk("t2_ad_wrap", ad2, 10'h000);
            if (busrq2_n) begin
                lat2 = n;
                break;
            end
        end
        busak2_n = 1'b0;
        busak2_n = 1'b1;
        tick();
        chk("t2_release_lat", lat2, 34);
        chk("t2_we_count", wr2 - base, 32);
        mism = 0;
        for (int i = 0; i < 32; i++) begin
            logic [9:0] a;
            a = 10'h3F0 + 10'(i);
            if (log2[(base + i) % 64] !== {10'(i), a[7:0]}) mism++;
        end
        chk("t2_data_mism", mism, 0);
        chk("t2_done_cs", {dn2 - dbase, dma_cs2, err2}, {32'd1, 2'b00});

        // reset mid-transfer at index 50
        vb = 1'b0;
        tick();
        vb = 1'b1;
        tick();
        busak_n = 1'b0;
        tick();
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (obj_we && obj_addr == 10'd49) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_reached_idx50", ok, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_release", {busrq_n, dma_cs, busy, obj_we}, 4'b1000);
        busak_n = 1'b1;
        vb = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("t6_err_clear", err, 1'b0);
        base  = wr1;
        dbase = dn1;
        run1(2, -10, lat_rel, lat_we);
        tick();
        chk("t6_release_lat", lat_rel, 770);
        chk("t6_we_count", wr1 - base, 768);
        chk("t6_data_mism", bad1(base, 768, 10'h000), 0);
        chk("t6_done_err", {dn1 - dbase, err}, {32'd1, 1'b0});

        // no grant: timeout
        base  = wr1;
        dbase = dn1;
        vb = 1'b0;
        tick();
        vb = 1'b1;
        tick();
        chk("t3_req", {busrq_n, busy}, 2'b01);
        lat_rel = -1;
        for (int n = 1; n <= 400; n++) begin
            tick();
            if (busrq_n) begin
                lat_rel = n;
                break;
            end
        end
        chk("t3_timeout_lat", lat_rel, 255);
        chk("t3_err_busy", {err, busy, dma_cs}, 3'b100);
        chk("t3_no_writes", {wr1 - base, dn1 - dbase}, 64'd0);

        // bus lost at index 100, with a cen stall on the way
        rst_n = 1'b0;
        vb = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t4_err_after_rst", err, 1'b0);
        base  = wr1;
        dbase = dn1;
        vb = 1'b1;
        tick();
        busak_n = 1'b0;
        tick();
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (obj_we && obj_addr == 10'd20) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_reached_idx21", ok, 1'b1);
        chk("t4_ad_at_idx21", ad, 10'd22);
        cen = 1'b0;
        ok = 1'b1;
        repeat (4) begin
            tick();
            if (obj_we !== 1'b0 || ad !== 10'd22 || busrq_n !== 1'b0) ok = 1'b0;
        end
        chk("t4_cen_stall", ok, 1'b1);
        cen = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (obj_we && obj_addr == 10'd99) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_reached_idx100", ok, 1'b1);
        busak_n = 1'b1;
        tick();
        chk("t4_abort_outs", {busrq_n, dma_cs, err, busy}, 4'b1010);
        repeat (10) tick();
        w = wr1 - base;
        chk("t4_we_at_most_100", (w <= 100) && (w >= 99), 1'b1);
        chk("t4_data_mism", bad1(base, w, 10'h000), 0);
        chk("t4_no_done", dn1 - dbase, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
